// File: rtl/sonar_pkg.sv
// sonar_pkg: register map, status bit positions and filter FSM states
package sonar_pkg;
    localparam logic [4:0] ADDR_DIST   = 5'd0;
    localparam logic [4:0] ADDR_AVG    = 5'd1;
    localparam logic [4:0] ADDR_STATUS = 5'd2;
    localparam logic [4:0] ADDR_THRESH = 5'd3;
    localparam logic [4:0] ADDR_CTRL   = 5'd4;
    localparam int BIT_BUSY      = 0;
    localparam int BIT_NEW       = 1;
    localparam int BIT_AVG_VALID = 2;
    localparam int BIT_ALARM     = 3;
    typedef enum logic [1:0] {S_IDLE, S_DIV, S_AVG, S_CMP} state_t;
endpackage

// File: rtl/seq_divider.sv
// seq_divider: 32-cycle radix-2 restoring divider; quotient is valid combinationally while done is high
module seq_divider (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic        done,
    output logic [31:0] quotient
);
    logic [31:0] q;
    logic [15:0] r;
    logic [4:0]  cnt;
    logic        run;
    logic [16:0] r_sh;
    logic        ge;
    always_comb begin
        r_sh = {r, q[31]};
        ge = r_sh >= {1'b0, divisor};
    end
    assign quotient = {q[30:0], ge};
    assign done = run && cnt == 5'd31;
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
            r <= '0;
            cnt <= '0;
            run <= 1'b0;
        end else if (start) begin
            q <= dividend;
            r <= '0;
            cnt <= '0;
            run <= 1'b1;
        end else if (run) begin
            q <= quotient;
            r <= ge ? 16'(r_sh - {1'b0, divisor}) : r_sh[15:0];
            cnt <= cnt + 5'd1;
            run <= !done;
        end
    end
endmodule

// File: rtl/sonar_dist_filter_core.sv
// sonar_dist_filter_core: echo ticks -> cm, moving average and hysteretic proximity alarm behind an MMIO register bank
module sonar_dist_filter_core
    import sonar_pkg::*;
#(
    parameter int TICKS_PER_CM = 5800,
    parameter int AVG_LOG2     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    input  logic        meas_valid,
    input  logic [31:0] meas_ticks,
    input  logic        meas_timeout,
    output logic        alarm
);
    localparam int N  = 1 << AVG_LOG2;
    localparam int SW = 16 + AVG_LOG2;
    state_t state, state_nxt;
    logic [15:0] dist_cm, avg_cm, near_th, far_th, drop_cnt;
    logic [7:0]  timeout_cnt;
    logic [SW-1:0] sum, sum_nxt;
    logic [15:0] ring [N];
    logic [AVG_LOG2-1:0] wp;
    logic avg_valid, new_flag, busy;
    logic div_start, div_done;
    logic [31:0] div_q;
    logic wr, clr_new, clr_filt;
    logic unused_read;
    assign unused_read = read;
    assign busy = state != S_IDLE;
    assign div_start = state == S_IDLE && meas_valid;
    assign wr = cs && write;
    assign clr_new = wr && addr == ADDR_CTRL && wr_data[0];
    assign clr_filt = wr && addr == ADDR_CTRL && wr_data[1];
    seq_divider u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (meas_ticks),
        .divisor  (16'(TICKS_PER_CM)),
        .done     (div_done),
        .quotient (div_q)
    );
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        state_nxt = (state == S_IDLE) ? (meas_valid ? S_DIV : S_IDLE) :
                    (state == S_DIV)  ? (div_done ? S_AVG : S_DIV) :
                    (state == S_AVG)  ? S_CMP : S_IDLE;
    end
    // First sample after a clear fills the whole window so the average starts at that sample
    always_comb begin
        sum_nxt = '0;
        sum_nxt = avg_valid ? sum - SW'(ring[wp]) + SW'(dist_cm) : SW'(dist_cm) << AVG_LOG2;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            dist_cm <= '0;
            avg_cm <= '0;
            sum <= '0;
            for (int i = 0; i < N; i++) ring[i] <= '0;
            wp <= '0;
            avg_valid <= 1'b0;
            new_flag <= 1'b0;
            alarm <= 1'b0;
            drop_cnt <= '0;
            timeout_cnt <= '0;
            near_th <= '0;
            far_th <= '0;
        end else begin
            if (div_done) dist_cm <= |div_q[31:16] ? 16'hFFFF : div_q[15:0];
            if (state == S_AVG) begin
                sum <= sum_nxt;
                avg_cm <= sum_nxt[SW-1:AVG_LOG2];
                if (!avg_valid) begin
                    for (int i = 0; i < N; i++) ring[i] <= dist_cm;
                    avg_valid <= 1'b1;
                end else begin
                    ring[wp] <= dist_cm;
                    wp <= wp + 1'b1;
                end
            end
            if (state == S_CMP) alarm <= (avg_cm < near_th) ? 1'b1 : (avg_cm >= far_th) ? 1'b0 : alarm;
            new_flag <= (state == S_CMP) || (new_flag && !clr_new);
            if (meas_valid && busy && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            if (meas_timeout && timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
            if (wr && addr == ADDR_THRESH) {far_th, near_th} <= wr_data;
            if (clr_filt) begin
                avg_valid <= 1'b0;
                wp <= '0;
                sum <= '0;
                avg_cm <= '0;
                drop_cnt <= '0;
                timeout_cnt <= '0;
            end
        end
    end
    always_comb begin
        rd_data = '0;
        rd_data = (addr == ADDR_DIST)   ? {16'h0, dist_cm} :
                  (addr == ADDR_AVG)    ? {16'h0, avg_cm} :
                  (addr == ADDR_STATUS) ? {drop_cnt, timeout_cnt, 4'b0, alarm, avg_valid, new_flag, busy} :
                  (addr == ADDR_THRESH) ? {far_th, near_th} : 32'h0;
    end
endmodule

// File: tb/tb_sonar_dist_filter_core.sv
// tb_sonar_dist_filter_core: directed scenario tests with hand-computed expectations
module tb_sonar_dist_filter_core;
    import sonar_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cs = 1'b0, read = 1'b0, write = 1'b0;
    logic [4:0] addr = '0;
    logic [31:0] wr_data = '0, rd_data;
    logic meas_valid = 1'b0, meas_timeout = 1'b0;
    logic [31:0] meas_ticks = '0;
    logic alarm;
    int n_cmp = 0, n_bad = 0;
    logic [31:0] d;

    sonar_dist_filter_core dut (
        .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data), .meas_valid(meas_valid),
        .meas_ticks(meas_ticks), .meas_timeout(meas_timeout), .alarm(alarm)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] v);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = v;
        tick();
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        cs = 1'b1; read = 1'b1; addr = a;
        @(negedge clk);
        v = rd_data;
        cs = 1'b0; read = 1'b0;
    endtask

    // Pulse one sample and wait until N+35 where alarm/new are valid
    task automatic sample(input logic [31:0] t);
        meas_ticks = t; meas_valid = 1'b1;
        tick();
        meas_valid = 1'b0;
        repeat (34) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        rd(ADDR_DIST, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_dist: got %h want 0", d); end
        rd(ADDR_AVG, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_avg: got %h want 0", d); end
        rd(ADDR_STATUS, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_status: got %h want 0", d); end
        rd(ADDR_THRESH, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_thresh: got %h want 0", d); end
        n_cmp++; if (alarm !== 1'b0) begin n_bad++; $display("FAIL reset_alarm: got %b want 0", alarm); end
    endtask

    task automatic test_basic();
        int busy_cycles = 0;
        int new_idx = -1;
        tick();
        addr = ADDR_STATUS;
        meas_ticks = 32'd580000; meas_valid = 1'b1;
        tick();
        meas_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rd_data[BIT_BUSY]) busy_cycles++;
            if (rd_data[BIT_NEW] && new_idx < 0) new_idx = i;
        end
        n_cmp++; if (busy_cycles !== 34) begin n_bad++; $display("FAIL basic_busy_cycles: got %0d want 34", busy_cycles); end
        n_cmp++; if (new_idx !== 34) begin n_bad++; $display("FAIL basic_new_latency: got %0d want 34", new_idx); end
        rd(ADDR_DIST, d);
        n_cmp++; if (d !== 32'd100) begin n_bad++; $display("FAIL basic_dist: got %0d want 100", d); end
        rd(ADDR_AVG, d);
        n_cmp++; if (d !== 32'd100) begin n_bad++; $display("FAIL basic_avg: got %0d want 100", d); end
        rd(ADDR_STATUS, d);
        n_cmp++; if (d !== 32'h6) begin n_bad++; $display("FAIL basic_status: got %h want 00000006", d); end
        n_cmp++; if (alarm !== 1'b0) begin n_bad++; $display("FAIL basic_alarm: got %b want 0", alarm); end
    endtask

    task automatic test_floor_sat();
        logic [31:0] t [3] = '{32'd20000, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] e [3] = '{32'd3, 32'h0000_FFFF, 32'd0};
        for (int i = 0; i < 3; i++) begin
            sample(t[i]);
            rd(ADDR_DIST, d);
            n_cmp++; if (d !== e[i]) begin n_bad++; $display("FAIL floor_sat_%0d: got %h want %h", i, d, e[i]); end
        end
    endtask

    task automatic test_hysteresis();
        logic [31:0] t [4] = '{32'd232000, 32'd406000, 32'd406000, 32'd406000};
        logic [31:0] ea [4] = '{32'd40, 32'd47, 32'd55, 32'd62};
        logic el [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        tick();
        wr(ADDR_CTRL, 32'h2);
        wr(ADDR_THRESH, {16'd60, 16'd50});
        for (int i = 0; i < 4; i++) begin
            sample(t[i]);
            rd(ADDR_AVG, d);
            n_cmp++; if (d !== ea[i]) begin n_bad++; $display("FAIL hyst_avg_%0d: got %0d want %0d", i, d, ea[i]); end
            n_cmp++; if (alarm !== el[i]) begin n_bad++; $display("FAIL hyst_alarm_%0d: got %b want %b", i, alarm, el[i]); end
        end
    endtask

    task automatic test_drop();
        tick();
        wr(ADDR_CTRL, 32'h2);
        meas_ticks = 32'd290000; meas_valid = 1'b1;
        tick();
        meas_valid = 1'b0;
        repeat (9) tick();
        meas_ticks = 32'd580000; meas_valid = 1'b1;
        tick();
        meas_valid = 1'b0;
        repeat (30) tick();
        for (int i = 0; i < 3; i++) begin
            meas_timeout = 1'b1;
            tick();
            meas_timeout = 1'b0;
            repeat (2) tick();
        end
        rd(ADDR_DIST, d);
        n_cmp++; if (d !== 32'd50) begin n_bad++; $display("FAIL drop_dist: got %0d want 50", d); end
        rd(ADDR_STATUS, d);
        n_cmp++; if (d[31:16] !== 16'd1) begin n_bad++; $display("FAIL drop_cnt: got %0d want 1", d[31:16]); end
        n_cmp++; if (d[15:8] !== 8'd3) begin n_bad++; $display("FAIL timeout_cnt: got %0d want 3", d[15:8]); end
        n_cmp++; if (d[BIT_BUSY] !== 1'b0) begin n_bad++; $display("FAIL drop_busy: got %b want 0", d[BIT_BUSY]); end
    endtask

    task automatic test_clear();
        tick();
        wr(ADDR_CTRL, 32'h2);
        rd(ADDR_STATUS, d);
        n_cmp++; if (d[31:8] !== 24'h0 || d[BIT_AVG_VALID] !== 1'b0) begin n_bad++; $display("FAIL clear_status: got %h want counters 0 avg_valid 0", d); end
        rd(ADDR_AVG, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL clear_avg: got %0d want 0", d); end
        sample(32'd464000);
        rd(ADDR_AVG, d);
        n_cmp++; if (d !== 32'd80) begin n_bad++; $display("FAIL clear_preload_avg: got %0d want 80", d); end
        tick();
        wr(ADDR_CTRL, 32'h1);
        rd(ADDR_STATUS, d);
        n_cmp++; if (d[BIT_NEW] !== 1'b0) begin n_bad++; $display("FAIL clear_new: got %b want 0", d[BIT_NEW]); end
    endtask

    task automatic test_reset_mid();
        tick();
        meas_ticks = 32'd580000; meas_valid = 1'b1;
        tick();
        meas_valid = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd(ADDR_STATUS, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL midreset_status: got %h want 0", d); end
        rd(ADDR_THRESH, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL midreset_thresh: got %h want 0", d); end
        n_cmp++; if (alarm !== 1'b0) begin n_bad++; $display("FAIL midreset_alarm: got %b want 0", alarm); end
        repeat (40) tick();
        rd(ADDR_STATUS, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL midreset_no_new: got %h want 0", d); end
        rd(ADDR_DIST, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL midreset_dist: got %0d want 0", d); end
        sample(32'd580000);
        rd(ADDR_DIST, d);
        n_cmp++; if (d !== 32'd100) begin n_bad++; $display("FAIL midreset_next_dist: got %0d want 100", d); end
        rd(ADDR_STATUS, d);
        n_cmp++; if (d !== 32'h6) begin n_bad++; $display("FAIL midreset_next_status: got %h want 00000006", d); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_floor_sat();
        test_hysteresis();
        test_drop();
        test_clear();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
